// File: rtl/sram_bridge.sv
// rtl/sram_bridge.sv - 32-bit CPU data port to 16-bit asynchronous SRAM bridge
//
// Each CPU word access becomes one or two half-word SRAM cycles (SETUP then a
// WAIT_CYCLES-long STROBE), low half first, skipping halves with no byte enables.
// Every SRAM pin and the CPU response come straight from flops.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   cpu_req/we/sel    request strobe, store flag, byte enables (sampled in IDLE)
//   cpu_addr/wdata    byte address ([1:0] ignored), store data
//   cpu_rdata/ready   load data and one-cycle completion pulse
//   sram_addr         half-word address
//   sram_dq_o/i/oe    write data, read data, bus drive enable
//   sram_ce_n/oe_n/we_n/be_n  active-low SRAM strobes and byte enables
module sram_bridge #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_sel,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_o,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [1:0]        sram_be_n
);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

    state_t            state_q, state_d;
    logic              half_q, half_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [ADDR_W-2:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       acc_q, acc_d;

    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]       dq_o_q, dq_o_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic [1:0]        be_n_q, be_n_d;

    logic [15:0]       rd_mask;
    logic              addr_unused;

    // Address bits outside the SRAM window and the byte offset play no part.
    assign addr_unused = ^{cpu_addr[31:ADDR_W+1], cpu_addr[1:0]};

    // Unselected bytes of the current half read back as zero.
    assign rd_mask = half_q ? {{8{sel_q[3]}}, {8{sel_q[2]}}}
                            : {{8{sel_q[1]}}, {8{sel_q[0]}}};

    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        acc_d       = acc_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        sram_addr_d = sram_addr_q;
        dq_o_d      = dq_o_q;
        dq_oe_d     = dq_oe_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        be_n_d      = be_n_q;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    sel_d   = cpu_sel;
                    addr_d  = cpu_addr[ADDR_W:2];
                    wdata_d = cpu_wdata;
                    acc_d   = '0;
                    if (cpu_sel == 4'b0000) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        // Skip the low half entirely when it has no enables.
                        half_d      = (cpu_sel[1:0] == 2'b00);
                        state_d     = SETUP;
                        sram_addr_d = {cpu_addr[ADDR_W:2], half_d};
                        ce_n_d      = 1'b0;
                        be_n_d      = half_d ? ~cpu_sel[3:2] : ~cpu_sel[1:0];
                        dq_oe_d     = cpu_we;
                        if (cpu_we) begin
                            dq_o_d = half_d ? cpu_wdata[31:16] : cpu_wdata[15:0];
                        end
                    end
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CNT_LAST;
                oe_n_d  = we_q;
                we_n_d  = ~we_q;
            end
            STROBE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    oe_n_d = 1'b1;
                    we_n_d = 1'b1;
                    if (!we_q) begin
                        if (half_q) acc_d[31:16] = sram_dq_i & rd_mask;
                        else        acc_d[15:0]  = sram_dq_i & rd_mask;
                    end
                    if (!half_q && (sel_q[3:2] != 2'b00)) begin
                        // dq_oe stays up: write data bridges straight into the next SETUP.
                        half_d      = 1'b1;
                        state_d     = SETUP;
                        sram_addr_d = {addr_q, 1'b1};
                        be_n_d      = ~sel_q[3:2];
                        if (we_q) dq_o_d = wdata_q[31:16];
                    end else begin
                        // dq_oe/dq_o are held through DONE so we_n rises before the bus is released.
                        state_d = DONE;
                        ce_n_d  = 1'b1;
                        be_n_d  = 2'b11;
                        ready_d = 1'b1;
                        rdata_d = acc_d;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                dq_oe_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            half_q      <= 1'b0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            acc_q       <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            sram_addr_q <= '0;
            dq_o_q      <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            be_n_q      <= 2'b11;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            acc_q       <= acc_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            sram_addr_q <= sram_addr_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            be_n_q      <= be_n_d;
        end
    end

    assign cpu_rdata  = rdata_q;
    assign cpu_ready  = ready_q;
    assign sram_addr  = sram_addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_be_n  = be_n_q;

endmodule

// File: tb/tb_sram_bridge.sv
// tb/tb_sram_bridge.sv - self-checking bench for sram_bridge
module tb_sram_bridge;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cpu_req, cpu_we, cpu_ready;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [1:0]  sram_be_n;

    logic        c3_req, c3_we, c3_ready;
    logic [3:0]  c3_sel;
    logic [31:0] c3_addr, c3_wdata, c3_rdata;
    logic [19:0] s3_addr;
    logic [15:0] s3_dq_o, s3_dq_i;
    logic        s3_dq_oe, s3_ce_n, s3_oe_n, s3_we_n;
    logic [1:0]  s3_be_n;

    sram_bridge #(.ADDR_W(20), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_sel(cpu_sel),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    sram_bridge #(.ADDR_W(20), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .cpu_req(c3_req), .cpu_we(c3_we), .cpu_sel(c3_sel),
        .cpu_addr(c3_addr), .cpu_wdata(c3_wdata), .cpu_rdata(c3_rdata), .cpu_ready(c3_ready),
        .sram_addr(s3_addr), .sram_dq_o(s3_dq_o), .sram_dq_i(s3_dq_i), .sram_dq_oe(s3_dq_oe),
        .sram_ce_n(s3_ce_n), .sram_oe_n(s3_oe_n), .sram_we_n(s3_we_n), .sram_be_n(s3_be_n)
    );

    // Asynchronous SRAM models and a byte-addressed reference memory.
    logic [15:0] mem  [0:1023];
    logic [15:0] mem3 [0:1023];
    logic [7:0]  ref_mem [0:2047];

    assign sram_dq_i = mem[sram_addr[9:0]];
    assign s3_dq_i   = mem3[s3_addr[9:0]];

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_be_n[0]) mem[sram_addr[9:0]][7:0]  = sram_dq_o[7:0];
            if (!sram_be_n[1]) mem[sram_addr[9:0]][15:8] = sram_dq_o[15:8];
        end
    end

    int tests_run = 0;
    int tests_failed = 0;
    int we_low, oe_low, ce_cnt, dqoe_cnt;
    logic [19:0] wa_q[$];
    logic [15:0] wd_q[$];
    logic [1:0]  wb_q[$];

    function automatic logic [15:0] pat3(input int i);
        return 16'((i * 263) ^ 16'h5A3C);
    endfunction

    function automatic int exp_lat(input logic [3:0] s);
        int n;
        n = 0;
        if (s[1:0] != 2'b00) n++;
        if (s[3:2] != 2'b00) n++;
        return 1 + n * (1 + 1);
    endfunction

    function automatic void ref_store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int base;
        base = int'(a[10:2]) * 4;
        for (int i = 0; i < 4; i++)
            if (s[i]) ref_mem[base + i] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [3:0] s);
        int base;
        logic [31:0] r;
        base = int'(a[10:2]) * 4;
        r = '0;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[8*i +: 8] = ref_mem[base + i];
        return r;
    endfunction

    // Issue one request and watch the SRAM pins until cpu_ready (bounded).
    task automatic do_access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
        bit done;
        we_low = 0; oe_low = 0; ce_cnt = 0; dqoe_cnt = 0;
        wa_q.delete(); wd_q.delete(); wb_q.delete();
        rdata = '0; lat = 0; done = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_sel = sel; cpu_addr = addr; cpu_wdata = wdata;
        while (!done && lat < 50) begin
            @(negedge clk);
            lat++;
            cpu_req = 1'b0;
            if (sram_we_n === 1'b0) begin
                we_low++;
                wa_q.push_back(sram_addr); wd_q.push_back(sram_dq_o); wb_q.push_back(sram_be_n);
            end
            if (sram_oe_n === 1'b0) oe_low++;
            if (sram_ce_n === 1'b0) ce_cnt++;
            if (sram_dq_oe === 1'b1) dqoe_cnt++;
            if (cpu_ready === 1'b1) begin
                done = 1;
                rdata = cpu_rdata;
            end
        end
        if (!done) begin
            tests_run++; tests_failed++;
            $display("FAIL access_timeout: no cpu_ready after %0d cycles, required one", lat);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe} !== 6'b111110) begin
            tests_failed++;
            $display("FAIL reset_strobes: got %b required 111110", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe});
        end
        tests_run++;
        if ({sram_addr, sram_dq_o} !== 36'h0) begin
            tests_failed++;
            $display("FAIL reset_addr_data: got %h required 0", {sram_addr, sram_dq_o});
        end
        tests_run++;
        if ({cpu_ready, cpu_rdata} !== 33'h0) begin
            tests_failed++;
            $display("FAIL reset_cpu: got %h required 0", {cpu_ready, cpu_rdata});
        end
        rst = 1'b1;
    endtask

    task automatic test_full_store;
        logic [31:0] rd; int lat;
        do_access(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, rd, lat);
        ref_store(32'h10, 4'b1111, 32'hDEADBEEF);
        tests_run++;
        if (lat !== 5) begin tests_failed++; $display("FAIL store_latency: got %0d required 5", lat); end
        tests_run++;
        if (we_low !== 2) begin tests_failed++; $display("FAIL store_we_cycles: got %0d required 2", we_low); end
        tests_run++;
        if ({wa_q[0], wa_q[1]} !== {20'h8, 20'h9}) begin
            tests_failed++; $display("FAIL store_addr: got %h %h required 8 9", wa_q[0], wa_q[1]);
        end
        tests_run++;
        if ({wd_q[0], wd_q[1]} !== {16'hBEEF, 16'hDEAD}) begin
            tests_failed++; $display("FAIL store_data: got %h %h required beef dead", wd_q[0], wd_q[1]);
        end
        tests_run++;
        if ({wb_q[0], wb_q[1]} !== 4'b0000) begin
            tests_failed++; $display("FAIL store_be: got %b %b required 00 00", wb_q[0], wb_q[1]);
        end
        tests_run++;
        if (dqoe_cnt !== 5) begin tests_failed++; $display("FAIL store_dq_hold: got %0d dq_oe cycles required 5", dqoe_cnt); end
    endtask

    task automatic test_full_load;
        logic [31:0] rd; int lat;
        do_access(1'b0, 4'b1111, 32'h10, 32'h0, rd, lat);
        tests_run++;
        if (rd !== ref_load(32'h10, 4'b1111)) begin
            tests_failed++; $display("FAIL load_data: got %h required %h", rd, ref_load(32'h10, 4'b1111));
        end
        tests_run++;
        if (lat !== 5) begin tests_failed++; $display("FAIL load_latency: got %0d required 5", lat); end
        tests_run++;
        if ({oe_low, dqoe_cnt, we_low} !== {32'd2, 32'd0, 32'd0}) begin
            tests_failed++; $display("FAIL load_strobes: got oe=%0d dq_oe=%0d we=%0d required 2 0 0", oe_low, dqoe_cnt, we_low);
        end
    endtask

    task automatic test_byte_store;
        logic [31:0] rd; int lat;
        do_access(1'b1, 4'b0100, 32'h10, 32'h00AA0000, rd, lat);
        ref_store(32'h10, 4'b0100, 32'h00AA0000);
        tests_run++;
        if (lat !== 3) begin tests_failed++; $display("FAIL byte_latency: got %0d required 3", lat); end
        tests_run++;
        if ({we_low, wa_q[0], wb_q[0], wd_q[0]} !== {32'd1, 20'h9, 2'b10, 16'h00AA}) begin
            tests_failed++; $display("FAIL byte_cycle: got we=%0d a=%h be=%b d=%h required 1 9 10 00aa", we_low, wa_q[0], wb_q[0], wd_q[0]);
        end
        do_access(1'b0, 4'b1111, 32'h10, 32'h0, rd, lat);
        tests_run++;
        if (rd !== ref_load(32'h10, 4'b1111)) begin
            tests_failed++; $display("FAIL byte_readback: got %h required %h", rd, ref_load(32'h10, 4'b1111));
        end
    endtask

    task automatic test_sel_zero;
        logic [31:0] rd; int lat;
        do_access(1'b0, 4'b0000, 32'h10, 32'h0, rd, lat);
        tests_run++;
        if ({lat, ce_cnt, rd} !== {32'd1, 32'd0, 32'h0}) begin
            tests_failed++; $display("FAIL sel0_load: got lat=%0d ce=%0d rdata=%h required 1 0 0", lat, ce_cnt, rd);
        end
        do_access(1'b1, 4'b0000, 32'h14, 32'hFFFFFFFF, rd, lat);
        tests_run++;
        if ({lat, ce_cnt, we_low} !== {32'd1, 32'd0, 32'd0}) begin
            tests_failed++; $display("FAIL sel0_store: got lat=%0d ce=%0d we=%0d required 1 0 0", lat, ce_cnt, we_low);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, a, d; logic [3:0] s; logic we; int lat;
        for (int k = 0; k < 40; k++) begin
            we = 1'($urandom_range(0, 1));
            s  = 4'($urandom_range(0, 15));
            a  = (32'($urandom_range(0, 1)) << 31) | (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(0, 3));
            d  = $urandom;
            do_access(we, s, a, d, rd, lat);
            tests_run++;
            if (lat !== exp_lat(s)) begin
                tests_failed++; $display("FAIL rand_latency[%0d]: sel=%b got %0d required %0d", k, s, lat, exp_lat(s));
            end
            if (we) begin
                ref_store(a, s, d);
                tests_run++;
                if (we_low !== (exp_lat(s) - 1) / 2) begin
                    tests_failed++; $display("FAIL rand_we_cycles[%0d]: got %0d required %0d", k, we_low, (exp_lat(s) - 1) / 2);
                end
            end else begin
                tests_run++;
                if (rd !== ref_load(a, s) || dqoe_cnt !== 0) begin
                    tests_failed++; $display("FAIL rand_load[%0d]: addr=%h sel=%b got %h dq_oe=%0d required %h 0", k, a, s, rd, dqoe_cnt, ref_load(a, s));
                end
            end
        end
    endtask

    task automatic test_reset_mid_store;
        logic [31:0] rd, d; int lat, ready_seen; bit found;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_sel = 4'b1111; cpu_addr = 32'h400; cpu_wdata = 32'h12345678;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            if (sram_we_n === 1'b0) found = 1;
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL rstmid_reach_strobe: got no we_n low required one"); end
        rst = 1'b0;
        #1;
        tests_run++;
        if ({sram_we_n, sram_ce_n, sram_oe_n, sram_dq_oe, cpu_ready} !== 5'b11100) begin
            tests_failed++; $display("FAIL rstmid_strobes: got %b required 11100", {sram_we_n, sram_ce_n, sram_oe_n, sram_dq_oe, cpu_ready});
        end
        ready_seen = 0;
        repeat (2) begin @(negedge clk); if (cpu_ready === 1'b1) ready_seen++; end
        rst = 1'b1;
        repeat (4) begin @(negedge clk); if (cpu_ready === 1'b1) ready_seen++; end
        tests_run++;
        if (ready_seen !== 0) begin tests_failed++; $display("FAIL rstmid_no_ready: got %0d pulses required 0", ready_seen); end
        d = $urandom;
        do_access(1'b1, 4'b1111, 32'h1F0, d, rd, lat);
        ref_store(32'h1F0, 4'b1111, d);
        do_access(1'b0, 4'b1111, 32'h1F0, 32'h0, rd, lat);
        tests_run++;
        if (rd !== ref_load(32'h1F0, 4'b1111) || lat !== 5) begin
            tests_failed++; $display("FAIL rstmid_resume: got %h lat=%0d required %h 5", rd, lat, ref_load(32'h1F0, 4'b1111));
        end
    endtask

    task automatic test_wait3_back_to_back;
        int lat, lat2, oe3, run, run_cnt, run_max;
        logic [31:0] rd1, rd2;
        bit done;
        @(negedge clk);
        c3_req = 1'b1; c3_we = 1'b0; c3_sel = 4'b1111; c3_addr = 32'h20; c3_wdata = 32'h0;
        lat = 0; oe3 = 0; run = 0; run_cnt = 0; run_max = 0; done = 0; rd1 = '0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
            if (s3_oe_n === 1'b0) begin
                oe3++; run++;
            end else if (run > 0) begin
                run_cnt++;
                if (run > run_max) run_max = run;
                run = 0;
            end
            if (c3_ready === 1'b1) begin done = 1; rd1 = c3_rdata; end
        end
        c3_addr = 32'h60;
        tests_run++;
        if (lat !== 9) begin tests_failed++; $display("FAIL w3_latency: got %0d required 9", lat); end
        tests_run++;
        if ({oe3, run_cnt, run_max} !== {32'd6, 32'd2, 32'd3}) begin
            tests_failed++; $display("FAIL w3_oe_runs: got total=%0d runs=%0d max=%0d required 6 2 3", oe3, run_cnt, run_max);
        end
        tests_run++;
        if (rd1 !== {pat3(17), pat3(16)}) begin
            tests_failed++; $display("FAIL w3_data1: got %h required %h", rd1, {pat3(17), pat3(16)});
        end
        lat2 = 0; done = 0; rd2 = '0;
        while (!done && lat2 < 60) begin
            @(negedge clk);
            lat2++;
            if (c3_ready === 1'b1) begin done = 1; rd2 = c3_rdata; end
        end
        c3_req = 1'b0;
        tests_run++;
        if (lat2 !== 10) begin tests_failed++; $display("FAIL w3_back_to_back: got %0d cycles required 10", lat2); end
        tests_run++;
        if (rd2 !== {pat3(49), pat3(48)}) begin
            tests_failed++; $display("FAIL w3_data2: got %h required %h", rd2, {pat3(49), pat3(48)});
        end
    endtask

    initial begin
        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_sel = '0; cpu_addr = '0; cpu_wdata = '0;
        c3_req = 1'b0; c3_we = 1'b0; c3_sel = '0; c3_addr = '0; c3_wdata = '0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = 16'h0;
            mem3[i] = pat3(i);
        end
        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h0;

        test_reset();
        test_full_store();
        test_full_load();
        test_byte_store();
        test_sel_zero();
        test_random();
        test_reset_mid_store();
        test_wait3_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/sram_bridge.md
# sram_bridge

Data-side external memory bridge between the CPU memory stage and the board's 16-bit asynchronous SRAM. It converts each 32-bit load/store request into up to two sequenced half-word SRAM cycles, with per-byte enables. It holds the pipeline via `cpu_ready` until the access completes. All SRAM control outputs are registered, so strobes are glitch-free.

## Interface
- `ADDR_W`, 20: SRAM half-word address width.
- `WAIT_CYCLES`, 1: strobe length in clocks per half access (≥1).

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  access request; sampled only in IDLE.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_sel`  in  4  byte enables; bit i selects `cpu_wdata[8i+7:8i]`.
- `cpu_addr`  in  32  byte address; bits [1:0] ignored.
- `cpu_wdata`  in  32  store data.
- `cpu_rdata`  out  32  load data; valid while `cpu_ready`=1.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `sram_addr`  out  ADDR_W  half-word address.
- `sram_dq_o`  out  16  write data.
- `sram_dq_i`  in  16  read data.
- `sram_dq_oe`  out  1  data bus drive enable (board tristate).
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  active-low chip enable, output enable, write enable.
- `sram_be_n`  out  2  active-low byte enables; [0] = low byte.

## Operation
- States: IDLE, SETUP, STROBE, DONE. A `half` register selects the low half (0) or the high half (1).
- IDLE, `cpu_req`=1: latch addr/we/sel/wdata and clear the rdata accumulator.
  - n = number of non-zero groups among `sel[1:0]` and `sel[3:2]`.
  - n=0: go to DONE.
  - Otherwise: go to SETUP with `half` = first non-zero group, low half first.
- SETUP, 1 cycle:
  - `sram_addr` = {`cpu_addr[ADDR_W:2]`, `half`}.
  - `ce_n`=0, `be_n` = ~sel bits of the current half, `oe_n`=1, `we_n`=1.
  - Store: `dq_oe`=1; `dq_o` = `wdata[15:0]` or `wdata[31:16]`.
- STROBE, WAIT_CYCLES cycles (down-counter):
  - Load: `oe_n`=0. On the last cycle, capture `sram_dq_i` into rdata half `half`, masked per byte by sel (unselected bytes read 0).
  - Store: `we_n`=0; `addr`, `be_n`, `dq_o` held stable.
  - Exit: if the high half is still pending and enabled, set `half`=1 and go to SETUP; else go to DONE.
- DONE, 1 cycle: `cpu_ready`=1, `cpu_rdata` = accumulator, `ce_n`=1, `be_n`=2'b11, then IDLE.
- Write data hold: `dq_oe` and `dq_o` stay driven one cycle past the final STROBE cycle (into the next SETUP or DONE). `we_n` therefore rises before the bus is released.
- `cpu_req` outside IDLE is ignored. If the CPU keeps `cpu_req` high in the cycle after DONE, that is accepted as a new request.

## Timing
- Reset (async, immediate) values:
  - state IDLE.
  - `ce_n`/`oe_n`/`we_n`=1, `be_n`=2'b11.
  - `dq_oe`=0, `dq_o`=0, `sram_addr`=0.
  - `cpu_ready`=0, `cpu_rdata`=0.
- Reset mid-access: strobes deassert combinationally with reset. No partial completion is reported. Resume in IDLE after release.
- Latency: request accepted in IDLE at cycle T0 gives `cpu_ready` at cycle T0 + 1 + n·(1+WAIT_CYCLES).
  - Default full word: T0+5.
  - Single half: T0+3.
  - `sel`=0: T0+1.
- `cpu_rdata` changes only in the cycle `cpu_ready` rises. It holds its value until the next capture.
- Outputs are all registered; no combinational path from `cpu_*` to `sram_*`.

## Test plan
- Reset: assert `rst`=0 mid-STROBE of a store → `we_n`, `ce_n` go high and `dq_oe` goes 0 the same cycle; after release, a new request completes normally.
- Full store, `addr`=0x00000010, `wdata`=0xDEADBEEF, `sel`=4'b1111 → `sram_addr`=0x8 written 0xBEEF with `be_n`=00, then 0x9 written 0xDEAD; `we_n` low 1 cycle each; `cpu_ready` at T0+5.
- Full load from the same address, SRAM model returning 0xBEEF/0xDEAD → `cpu_rdata`=0xDEADBEEF at T0+5; `oe_n` low only in STROBE; `dq_oe` never 1.
- Byte store, `sel`=4'b0100, `wdata`=0x00AA0000 → single access to addr 0x9, `be_n`=2'b10, `dq_o`=0x00AA; `cpu_ready` at T0+3.
- `sel`=4'b0000 → no `ce_n` activity; `cpu_ready` at T0+1; `cpu_rdata`=0.
- `WAIT_CYCLES`=3, full load, with `cpu_req` held high → `oe_n` low 3 cycles per half; `cpu_ready` at T0+9; back-to-back second request accepted the cycle after DONE.
